mole_controller: RTL and testbench
==================================

# mole_controller

Game-flow controller for the whack-a-mole design. Sits directly downstream of the LFSR hole generator: seeds it at game start, samples its 0–8 hole number to pop one mole at a time, times each mole's life, and scores player hits. It also counts misses and ends the game after a configurable limit. Mole lifetime shrinks as the score rises.

## Interface
Parameters:
- SPAWN_DELAY, 25_000_000: cycles between a mole ending and the next pick.
- LIFE_CYCLES, 50_000_000: initial mole-up time, in cycles.
- LIFE_STEP, 2_500_000: life reduction per successful hit.
- LIFE_MIN, 10_000_000: floor for the mole-up time.
- MAX_MISSES, 3: misses that end the game (1–15).
- RETRY_MAX, 64: PICK cycles before a repeat hole is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  level/pulse; begins a game from IDLE or OVER.
- rndnum  in  4  hole number from the LFSR, nominally 0–8.
- hit  in  9  one-cycle debounced strike strobes, one per hole.
- lfsr_load  out  1  one-cycle pulse that seeds the LFSR.
- mole  out  9  one-hot active mole, or 0.
- score  out  8  successful hits, saturating at 255.
- misses  out  4  expired moles this game.
- playing  out  1  high in SEED/GAP/PICK/UP.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, SEED, GAP, PICK, UP, OVER.
- **IDLE**
  - start → SEED.
- **SEED**
  - Lasts one cycle; lfsr_load=1.
  - Clears score and misses.
  - Sets cur_life=LIFE_CYCLES and last_hole=15 (none).
  - → GAP.
- **GAP**
  - Lasts SPAWN_DELAY cycles; mole=0.
  - → PICK.
- **PICK** (each cycle it samples rndnum):
  - Accept when rndnum≤8 and rndnum≠last_hole.
  - Also accept when retry_cnt reaches RETRY_MAX and rndnum≤8, even if it repeats last_hole.
  - Otherwise retry_cnt++ and stay in PICK.
  - On accept: hole=rndnum, last_hole=rndnum, retry_cnt=0, load life timer with cur_life → UP.
- **UP**
  - mole = 1<<hole.
  - hit[hole]=1: score++ (saturating), cur_life=max(LIFE_MIN, cur_life−LIFE_STEP) → GAP.
  - Hits on other holes are ignored.
  - Life timer expiring with no valid hit: misses++. If the new misses==MAX_MISSES → OVER, else → GAP.
- **OVER**
  - mole=0; score and misses hold.
  - start → SEED.
- start is ignored outside IDLE and OVER.
- Out-of-range rndnum (9–15) is never accepted.
- cur_life arithmetic must be wide enough for LIFE_CYCLES. Subtraction must clamp at LIFE_MIN with no underflow.

## Timing
- Reset (synchronous, any state): state=IDLE, mole=0, score=0, misses=0, lfsr_load=0, playing=0, game_over=0, retry_cnt=0, last_hole=15.
- All outputs are registered.
- start accepted at edge N → lfsr_load high in cycle N+1 (SEED) → GAP begins at N+2.
- mole rises the cycle after PICK accepts. It stays high for exactly cur_life cycles if not hit.
- A hit is sampled in any UP cycle, including the final timer cycle. A hit in the final cycle wins over expiry: it scores and does not count as a miss.
- After a valid hit: mole=0 and score is updated on the next cycle.
- Reset during UP drops mole in the cycle after reset is sampled.

## Structure
- Shared package wam_pkg holds:
  - NUM_HOLES=9 and NO_HOLE=4'd15.
  - The state encoding (IDLE, SEED, GAP, PICK, UP, OVER).
  - The score width.
- Sub-module mole_timer: a loadable down-counter with a done flag. Two instances: GAP delay and mole life.

## Test plan
Bench parameters: SPAWN_DELAY=4, LIFE_CYCLES=10, LIFE_STEP=3, LIFE_MIN=4, MAX_MISSES=3, RETRY_MAX=8.
- Reset, then start pulse → lfsr_load high for exactly one cycle. mole=0 for 4 cycles, then PICK.
- rndnum=5, hit[5] at UP cycle 3 → mole=9'h020 for 3 cycles, score=1. Next life is 7 cycles.
- Hold rndnum=5 after hole 5 → PICK stays 8 cycles, then accepts 5. rndnum=9 held → PICK never accepts.
- Hit only wrong holes and let the life expire, three times → misses=1, 2, 3; game_over=1 and mole=0 after the third.
- Four consecutive hits → life sequence 10, 7, 4, 4 (clamped). hit on the exact final UP cycle scores with no miss.
- Reset asserted mid-UP → all outputs return to reset values the next cycle. start is ignored while playing.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole design: hole count, the "no hole"
// marker, the controller state encoding, the score width and a one-hot helper.
package wam_pkg;

    localparam int         NUM_HOLES = 9;
    localparam logic [3:0] NO_HOLE   = 4'd15;
    localparam int         SCORE_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_GAP,
        S_PICK,
        S_UP,
        S_OVER
    } state_t;

    // One-hot hole mask; anything past the last hole gives an empty mask.
    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [3:0] h);
        logic [NUM_HOLES-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            r[i] = (h == 4'(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/mole_timer.sv
// Loadable down-counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val into the counter (wins over counting)
//   load_val   : start value, i.e. number of cycles until done
//   done       : high during the last counted cycle (count == 1)
// After a load of N, done is high in the N-th cycle following the load edge.
module mole_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/mole_controller.sv
// Game-flow controller: seeds the LFSR, picks holes from rndnum, times each
// mole, scores hits, counts misses and ends the game at MAX_MISSES.
//   clk, reset : clock, synchronous active-high reset
//   start      : begins a game from IDLE or OVER (ignored otherwise)
//   rndnum     : hole number from the LFSR (0-8 valid, 9-15 rejected)
//   hit        : per-hole strike strobes
//   lfsr_load  : one-cycle LFSR seed pulse (SEED)
//   mole       : one-hot active mole, 0 when none is up
//   score      : successful hits, saturating
//   misses     : expired moles this game
//   playing    : high in SEED/GAP/PICK/UP
//   game_over  : high in OVER
// All outputs are registered from the next-state values.
module mole_controller
    import wam_pkg::*;
#(
    parameter int SPAWN_DELAY = 25_000_000,
    parameter int LIFE_CYCLES = 50_000_000,
    parameter int LIFE_STEP   = 2_500_000,
    parameter int LIFE_MIN    = 10_000_000,
    parameter int MAX_MISSES  = 3,
    parameter int RETRY_MAX   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           rndnum,
    input  logic [NUM_HOLES-1:0] hit,
    output logic                 lfsr_load,
    output logic [NUM_HOLES-1:0] mole,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           misses,
    output logic                 playing,
    output logic                 game_over
);

    localparam int LW = $clog2(LIFE_CYCLES + 1);
    localparam int GW = $clog2(SPAWN_DELAY + 1);
    localparam int RW = $clog2(RETRY_MAX + 1);

    state_t         state, nstate;
    logic [3:0]     hole, last_hole, nhole;
    logic [RW-1:0]  retry_cnt;
    logic [LW-1:0]  cur_life, life_dec;
    logic           gap_done, life_done;
    logic           gap_load, life_load, accept, hit_ok, expire;
    logic           rnd_valid;

    mole_timer #(.W(GW)) u_gap (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GW'(SPAWN_DELAY)),
        .done     (gap_done)
    );

    mole_timer #(.W(LW)) u_life (
        .clk      (clk),
        .reset    (reset),
        .load     (life_load),
        .load_val (cur_life),
        .done     (life_done)
    );

    assign rnd_valid = (rndnum <= 4'(NUM_HOLES - 1));
    assign nhole     = accept ? rndnum : hole;

    // Clamp compare is done at 32 bits so the subtraction can never wrap.
    always_comb begin
        if (32'(cur_life) >= 32'(LIFE_MIN + LIFE_STEP)) begin
            life_dec = cur_life - LW'(LIFE_STEP);
        end else begin
            life_dec = LW'(LIFE_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate    = state;
        gap_load  = 1'b0;
        life_load = 1'b0;
        accept    = 1'b0;
        hit_ok    = 1'b0;
        expire    = 1'b0;
        case (state)
            S_IDLE: if (start) nstate = S_SEED;
            S_SEED: begin
                gap_load = 1'b1;
                nstate   = S_GAP;
            end
            S_GAP:  if (gap_done) nstate = S_PICK;
            S_PICK: begin
                // A repeat of the previous hole is only taken once the retry
                // budget is used up; out-of-range values are never taken.
                if (rnd_valid && (rndnum != last_hole || retry_cnt == RW'(RETRY_MAX))) begin
                    accept    = 1'b1;
                    life_load = 1'b1;
                    nstate    = S_UP;
                end
            end
            S_UP: begin
                // A hit in the final timer cycle beats expiry.
                if (hit[hole]) begin
                    hit_ok   = 1'b1;
                    gap_load = 1'b1;
                    nstate   = S_GAP;
                end else if (life_done) begin
                    expire = 1'b1;
                    if (misses + 4'd1 == 4'(MAX_MISSES)) begin
                        nstate = S_OVER;
                    end else begin
                        gap_load = 1'b1;
                        nstate   = S_GAP;
                    end
                end
            end
            S_OVER: if (start) nstate = S_SEED;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hole      <= 4'd0;
            last_hole <= NO_HOLE;
            retry_cnt <= '0;
            cur_life  <= LW'(LIFE_CYCLES);
            score     <= '0;
            misses    <= 4'd0;
            mole      <= '0;
            lfsr_load <= 1'b0;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            if (state == S_SEED) begin
                score     <= '0;
                misses    <= 4'd0;
                cur_life  <= LW'(LIFE_CYCLES);
                last_hole <= NO_HOLE;
            end
            if (accept) begin
                hole      <= rndnum;
                last_hole <= rndnum;
                retry_cnt <= '0;
            end else if (state == S_PICK && retry_cnt != RW'(RETRY_MAX)) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            if (hit_ok) begin
                if (score != '1) score <= score + SCORE_W'(1);
                cur_life <= life_dec;
            end
            if (expire) misses <= misses + 4'd1;
            mole      <= (nstate == S_UP) ? hole_onehot(nhole) : '0;
            lfsr_load <= (nstate == S_SEED);
            playing   <= (nstate inside {S_SEED, S_GAP, S_PICK, S_UP});
            game_over <= (nstate == S_OVER);
        end
    end

endmodule

// File: tb/tb_mole_controller.sv
// Scoreboarded bench for mole_controller. Each planned mole pushes its
// expected hole, idle-gap length, up time and post-mole score/misses/over;
// a monitor measures each mole on the outputs and compares on its fall.
module tb_mole_controller;

    localparam int SD = 4, LC = 10, LS = 3, LM = 4, MM = 3, RM = 8;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] rndnum;
    logic [8:0] hit;
    logic       lfsr_load, playing, game_over;
    logic [8:0] mole;
    logic [7:0] score;
    logic [3:0] misses;

    always #5 clk = ~clk;

    mole_controller #(
        .SPAWN_DELAY (SD), .LIFE_CYCLES (LC), .LIFE_STEP (LS),
        .LIFE_MIN (LM), .MAX_MISSES (MM), .RETRY_MAX (RM)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .rndnum (rndnum), .hit (hit),
        .lfsr_load (lfsr_load), .mole (mole), .score (score), .misses (misses),
        .playing (playing), .game_over (game_over)
    );

    typedef struct {
        int hole; int gap; int up; int score; int misses; int over;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0, checks = 0;
    bit   sb_en = 1'b0, abort = 1'b0;
    int   next_r, m_score, m_miss, m_last;
    bit   m_first;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Mole life as a closed form of the score: LC - LS*score, floored at LM.
    function automatic int life_of(input int s);
        int l;
        l = LC - LS * s;
        return (l < LM) ? LM : l;
    endfunction

    function automatic int idx_of(input logic [8:0] v);
        for (int i = 0; i < 9; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Monitor: gap = cycles with playing && no mole before a rise.
    initial begin : mon
        logic [8:0] prev;
        int zc, uc, rh, rg;
        exp_t e;
        prev = '0; zc = 0; uc = 0; rh = 0; rg = 0;
        forever begin
            @(negedge clk);
            if (!sb_en) begin
                prev = '0; zc = 0; uc = 0;
            end else begin
                if (mole != '0) begin
                    if (prev == '0) begin
                        rh = idx_of(mole); rg = zc; uc = 1;
                    end else begin
                        uc++;
                    end
                end else begin
                    if (prev != '0) begin
                        chk("sb_pending", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("hole", rh, e.hole);
                            chk("gap", rg, e.gap);
                            chk("up_len", uc, e.up);
                            chk("score", int'(score), e.score);
                            chk("misses", int'(misses), e.misses);
                            chk("game_over", int'(game_over), e.over);
                        end
                        zc = 0;
                    end
                    if (playing) zc++;
                end
                prev = mole;
            end
        end
    end

    // k = UP cycle of the hit (0 = let it expire); nr = rndnum for next mole.
    task automatic run_mole(input int k, input int nr);
        exp_t e;
        int r, life, pick, up, t, w;
        r    = next_r;
        life = life_of(m_score);
        pick = (r == m_last) ? RM + 1 : 1;
        up   = (k > 0) ? k : life;
        e.hole = r;
        e.gap  = (m_first ? 1 : 0) + SD + pick;
        e.up   = up;
        if (k > 0) m_score++; else m_miss++;
        m_last = r; m_first = 1'b0;
        e.score = m_score; e.misses = m_miss; e.over = int'(m_miss == MM);
        exp_q.push_back(e);
        t = 0;
        while (mole == '0 && t < 400) begin
            @(negedge clk); t++;
        end
        if (mole == '0) begin
            chk("mole_rise_timeout", t, 0);
            abort = 1'b1;
            return;
        end
        next_r = nr;
        rndnum = 4'(nr);
        for (int j = 1; j <= up; j++) begin
            w = $urandom_range(0, 8);
            if (j == k) hit = 9'(1 << r);
            else if (w != r && $urandom_range(0, 1) == 1) hit = 9'(1 << w);
            else hit = '0;
            @(negedge clk);
        end
        hit = '0;
    endtask

    task automatic start_game();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_score = 0; m_miss = 0; m_last = 15; m_first = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mole"}, int'(mole), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_misses"}, int'(misses), 0);
        chk({tag, "_lfsr_load"}, int'(lfsr_load), 0);
        chk({tag, "_playing"}, int'(playing), 0);
        chk({tag, "_game_over"}, int'(game_over), 0);
    endtask

    initial begin
        int nz, ll, t, life, k, nr, cnt;
        reset = 1'b1; start = 1'b0; rndnum = 4'd9; hit = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // Seed pulse, then out-of-range rndnum must never be accepted and
        // start must be ignored while playing.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lfsr_load_seed", int'(lfsr_load), 1);
        chk("playing_seed", int'(playing), 1);
        @(negedge clk);
        chk("lfsr_load_once", int'(lfsr_load), 0);
        nz = 0; ll = 0;
        for (int i = 0; i < 40; i++) begin
            start = (i == 20);
            @(negedge clk);
            if (mole != '0) nz++;
            if (lfsr_load) ll++;
        end
        start = 1'b0;
        chk("no_accept_9", nz, 0);
        chk("start_ignored", ll, 0);
        chk("still_playing", int'(playing), 1);

        // Reset while a mole is up.
        rndnum = 4'd4;
        t = 0;
        while (mole == '0 && t < 50) begin
            @(negedge clk); t++;
        end
        chk("mole_h4", int'(mole), 9'h010);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_up");
        reset = 1'b0;

        // Directed game: life 10,7,4,4 with final-cycle hits, retry on a
        // repeated hole, then three expiries ending the game.
        next_r = 5; rndnum = 4'd5;
        sb_en = 1'b1;
        start_game();
        run_mole(3, 5);
        run_mole(7, 2);
        run_mole(4, 7);
        run_mole(4, 1);
        run_mole(0, 1);
        run_mole(0, 3);
        run_mole(0, 6);

        // Random games, each restarted from OVER.
        for (int g = 0; g < 3 && !abort; g++) begin
            start_game();
            cnt = 0;
            while (m_miss < MM && !abort) begin
                life = life_of(m_score);
                if (cnt >= 20 || $urandom_range(0, 9) >= 6) k = 0;
                else if ($urandom_range(0, 2) == 0) k = life;
                else k = $urandom_range(1, life);
                nr = ($urandom_range(0, 3) == 0) ? next_r : $urandom_range(0, 8);
                run_mole(k, nr);
                cnt++;
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
